accum_ring_buffer: RTL and testbench
====================================

Name: accum_ring_buffer

Overview:
Parametrised successor to the single-lane keyed accumulating FIFO. It sits between an AXI-Stream producer of keyed partial results and a downstream consumer. Each input beat carries a slot key and a value. The value is merged into that slot of a circular RAM: an empty slot stores the beat, an occupied slot is summed. Slots are drained in ring order once they are "closed", with a proper valid/ready handshake, late-data detection, a flush, and wrap or saturate arithmetic.

Parameters:
ABITS, 7, slot address bits; DEPTH = 2**ABITS
DBITS, 64, stream data width
VBITS, 32, value field width, din[VBITS-1:0]; must satisfy VBITS <= KEY_LSB
KEY_LSB, 32, LSB of the key field din[KEY_LSB+ABITS-1:KEY_LSB]; KEY_LSB+ABITS <= DBITS
LAG, 2, a slot closes when the newest key is LAG or more slots ahead of it
LATE_WIN, 4, keys within LATE_WIN slots behind rd_ptr are late; LAG+LATE_WIN < DEPTH
SATURATE, 0, 0 = wrap the value sum modulo 2**VBITS, 1 = clamp to all-ones
EMIT_EMPTY, 0, 1 = closed empty slots emit a beat, 0 = they are skipped silently

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
din  in  DBITS  input beat: key field and value field
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
dout  out  DBITS  output beat
flush  in  1  level: close slots until the ring is empty
occupancy  out  ABITS+1  number of valid slots
late_drop_cnt  out  16  late beats dropped; saturates at 0xFFFF

Behaviour:
- Reset (asynchronous assert, synchronous release): all slot valid bits = 0; rd_ptr = 0; head = 0; occupancy = 0; late_drop_cnt = 0; m_axis_tvalid = 0; dout = 0; s_axis_tready = 0. One cycle after reset_n rises, s_axis_tready = 1 and stays 1. Writes are single-cycle, so there is no input backpressure.
- Slot RAM contents are not cleared by reset. The valid bits define occupancy.
- Distances are computed modulo DEPTH: d(k) = k - rd_ptr, dh = head - rd_ptr.
- An input beat is accepted when s_axis_tvalid & s_axis_tready.
- Late beat: d(key) >= DEPTH - LATE_WIN. The beat is dropped and late_drop_cnt increments; no state changes.
- Non-late beat:
  - Slot invalid: store din and set valid; occupancy +1.
  - Slot valid: value field = sum of old and new value (wrap or clamp per SATURATE); upper bits keep the first beat's contents.
  - head <= key when d(key) > dh. Head never moves backward.
- Slot rd_ptr is closed when dh >= LAG, or when flush = 1 and occupancy != 0.
- Load: happens when rd_ptr is closed and the output register is free (m_axis_tvalid = 0, or m_axis_tready = 1 this cycle).
  - Valid slot: dout <= slot contents; m_axis_tvalid <= 1; valid bit cleared; occupancy -1; rd_ptr +1.
  - Invalid slot, EMIT_EMPTY = 1: dout gets key field = rd_ptr and all other bits 0; m_axis_tvalid <= 1; rd_ptr +1.
  - Invalid slot, EMIT_EMPTY = 0: rd_ptr +1 and no beat is emitted. Skipping runs at one slot per cycle.
- Output latency: one cycle from close to m_axis_tvalid. At most one load per cycle; full throughput is one beat per cycle.
- AXI rules: dout and m_axis_tvalid are held stable until m_axis_tready.
- Write and load to the same slot in the same cycle: the incoming value is merged into the word loaded into dout (bypass). The slot ends invalid, occupancy nets correctly, and nothing is lost.
- Simultaneous write to a new slot and load from another slot: occupancy is unchanged.
- Wrap-around: rd_ptr, head and keys wrap at DEPTH. The late window makes stale keys from the previous lap detectable.
- When rd_ptr == head and flush = 0, nothing is closed and the output idles.
- Flush stops once occupancy = 0 and any pending output beat has been accepted.
- Asserting reset_n low mid-transfer aborts immediately: m_axis_tvalid drops to 0 and any pending output beat is lost.

Test Plan:
1. Write key 3 value 5, then key 3 value 7, then key 6 value 1 (LAG = 2). Slot 0 through slot 4 close in turn: slots 0–2 are skipped silently, slot 3 emits dout[31:0] = 12 with key 3, slot 4 is skipped. occupancy goes 1 → 2 → 1.
2. SATURATE = 1: key 2 value 0xFFFFFFF0, then key 2 value 0x20, then key 9. Output value = 0xFFFFFFFF. Repeat with SATURATE = 0: output value = 0x10.
3. Hold m_axis_tready = 0 for 5 cycles while two slots are closed. dout stays stable. On release, two beats come out on consecutive cycles.
4. With rd_ptr = 10, write key 8. late_drop_cnt = 1, occupancy unchanged, no output.
5. Write keys 1 and 2, then hold flush = 1 with EMIT_EMPTY = 1. Output beats for keys 0, 1, 2 in order (key 0 with value 0). Then occupancy = 0 and the output idles.
6. Write key 0 in the same cycle slot 0 is loaded. The emitted beat includes the new value and occupancy returns to 0. Then pulse reset_n low mid-stream: m_axis_tvalid = 0, occupancy = 0, late_drop_cnt = 0.

Source files
------------

// File: rtl/accum_ring_buffer_if.sv
// accum_ring_buffer_if: input and output AXI-Stream handshake bundle for the accumulating ring buffer
interface accum_ring_buffer_if #(
    parameter int DBITS = 64
);
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [DBITS-1:0] din;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [DBITS-1:0] dout;

    modport master (
        output s_axis_tvalid, din, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, dout
    );

    modport slave (
        input  s_axis_tvalid, din, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, dout
    );
endinterface

// File: rtl/accum_ring_buffer.sv
// accum_ring_buffer: keyed accumulating circular buffer draining closed slots in ring order
module accum_ring_buffer #(
    parameter int ABITS      = 7,
    parameter int DBITS      = 64,
    parameter int VBITS      = 32,
    parameter int KEY_LSB    = 32,
    parameter int LAG        = 2,
    parameter int LATE_WIN   = 4,
    parameter int SATURATE   = 0,
    parameter int EMIT_EMPTY = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    accum_ring_buffer_if.slave   bus,
    input  logic                 flush,
    output logic [ABITS:0]       occupancy,
    output logic [15:0]          late_drop_cnt
);
    localparam int DEPTH = 1 << ABITS;
    localparam logic [ABITS:0] LATE_TH = (ABITS+1)'(DEPTH - LATE_WIN);
    localparam logic [ABITS:0] LAG_TH  = (ABITS+1)'(LAG);

    logic [DBITS-1:0] ram_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [ABITS-1:0] rd_ptr_q, rd_ptr_d, head_q, head_d;
    logic [ABITS:0]   occ_q, occ_d;
    logic [15:0]      late_cnt_q, late_cnt_d;
    logic             m_valid_q, m_valid_d, s_ready_q;
    logic [DBITS-1:0] dout_q, dout_d;

    logic [ABITS-1:0] key, dk, dh;
    logic             acc, late, wr, slot_valid, closed, load, bypass, eff_valid, emit;
    logic [DBITS-1:0] old_word, merged, load_word, empty_word;
    logic [VBITS:0]   sum;
    logic [VBITS-1:0] sum_v;

    // merge the incoming beat into its slot and decide whether rd_ptr is drained this cycle
    always_comb begin
        key        = bus.din[KEY_LSB +: ABITS];
        dk         = key - rd_ptr_q;
        dh         = head_q - rd_ptr_q;
        acc        = bus.s_axis_tvalid & s_ready_q;
        late       = {1'b0, dk} >= LATE_TH;
        wr         = acc & ~late;
        slot_valid = valid_q[key];
        old_word   = ram_q[key];
        sum        = {1'b0, old_word[VBITS-1:0]} + {1'b0, bus.din[VBITS-1:0]};
        sum_v      = (SATURATE != 0 && sum[VBITS]) ? {VBITS{1'b1}} : sum[VBITS-1:0];
        merged     = slot_valid ? {old_word[DBITS-1:VBITS], sum_v} : bus.din;
        closed     = ({1'b0, dh} >= LAG_TH) | (flush & (occ_q != '0));
        load       = closed & (~m_valid_q | bus.m_axis_tready);
        bypass     = wr & load & (key == rd_ptr_q);
        eff_valid  = valid_q[rd_ptr_q] | bypass;
        emit       = load & (eff_valid | (EMIT_EMPTY != 0));
        empty_word = '0;
        empty_word[KEY_LSB +: ABITS] = rd_ptr_q;
        load_word  = eff_valid ? (bypass ? merged : ram_q[rd_ptr_q]) : empty_word;
    end

    // next-state for pointers, counters, valid bits and the output register
    always_comb begin
        valid_d = valid_q;
        if (wr) valid_d[key] = 1'b1;
        if (load) valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d   = rd_ptr_q + ABITS'(load);
        // head is dragged along when the drain passes it so an emptied ring reads as idle
        head_d     = (wr && dk > dh) ? key : (load && dh == '0) ? rd_ptr_q + ABITS'(1) : head_q;
        occ_d      = occ_q + (ABITS+1)'(wr & ~slot_valid) - (ABITS+1)'(load & eff_valid);
        late_cnt_d = late_cnt_q + 16'(acc & late & ~&late_cnt_q);
        m_valid_d  = emit | (m_valid_q & ~bus.m_axis_tready);
        dout_d     = emit ? load_word : dout_q;
    end

    // slot storage, deliberately left uninitialised by reset
    always_ff @(posedge clock) begin
        if (wr) ram_q[key] <= merged;
    end

    // control state with asynchronous reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            head_q     <= '0;
            occ_q      <= '0;
            late_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            dout_q     <= '0;
            s_ready_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rd_ptr_q   <= rd_ptr_d;
            head_q     <= head_d;
            occ_q      <= occ_d;
            late_cnt_q <= late_cnt_d;
            m_valid_q  <= m_valid_d;
            dout_q     <= dout_d;
            s_ready_q  <= 1'b1;
        end
    end

    assign bus.s_axis_tready = s_ready_q;
    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.dout          = dout_q;
    assign occupancy         = occ_q;
    assign late_drop_cnt     = late_cnt_q;
endmodule

// File: tb/tb_accum_ring_buffer.sv
// tb_accum_ring_buffer: two parameter variants driven together and checked against a slot-level model
module tb_accum_ring_buffer;
    localparam int DEPTH = 128, LAG = 2, LATE_WIN = 4;

    logic        clock = 0, reset_n = 0, sv = 0, tready = 1, flush = 0;
    logic [63:0] din_r = '0;
    logic [7:0]  occ0, occ1;
    logic [15:0] late0, late1;
    int          n_chk = 0, n_fail = 0;
    logic [63:0] q0[$], q1[$];

    // model state, index 0 = wrap/skip variant, index 1 = saturate/emit-empty variant
    logic [63:0] m_mem[2][DEPTH];
    bit          m_vld[2][DEPTH];
    int          m_rd[2], m_head[2], m_occ[2], m_late[2];
    bit          m_mv[2], m_rdy[2];
    logic [63:0] m_dout[2];

    accum_ring_buffer_if #(.DBITS(64)) bus0 ();
    accum_ring_buffer_if #(.DBITS(64)) bus1 ();
    assign bus0.s_axis_tvalid = sv;
    assign bus0.din           = din_r;
    assign bus0.m_axis_tready = tready;
    assign bus1.s_axis_tvalid = sv;
    assign bus1.din           = din_r;
    assign bus1.m_axis_tready = tready;

    accum_ring_buffer #(.SATURATE(0), .EMIT_EMPTY(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0), .flush(flush),
        .occupancy(occ0), .late_drop_cnt(late0)
    );
    accum_ring_buffer #(.SATURATE(1), .EMIT_EMPTY(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1), .flush(flush),
        .occupancy(occ1), .late_drop_cnt(late1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < DEPTH; s++) m_vld[i][s] = 0;
            m_rd[i] = 0; m_head[i] = 0; m_occ[i] = 0; m_late[i] = 0;
            m_mv[i] = 0; m_rdy[i] = 0; m_dout[i] = '0;
        end
    endtask

    // one clock of the slot-level rules: merge the beat, then drain the ring head
    task automatic model_step(input int i);
        int key, dk, dh;
        bit acc, load, em;
        logic [63:0] t, w;
        logic [32:0] s;
        key  = int'(din_r[38:32]);
        acc  = sv && m_rdy[i];
        dk   = (key - m_rd[i] + DEPTH) % DEPTH;
        dh   = (m_head[i] - m_rd[i] + DEPTH) % DEPTH;
        load = (dh >= LAG || (flush && m_occ[i] != 0)) && (!m_mv[i] || tready);
        em   = 0;
        w    = '0;
        if (acc && dk >= DEPTH - LATE_WIN) begin
            if (m_late[i] < 65535) m_late[i]++;
        end else if (acc) begin
            t = m_mem[i][key];
            if (m_vld[i][key]) begin
                s = {1'b0, t[31:0]} + {1'b0, din_r[31:0]};
                t[31:0] = (i == 1 && s[32]) ? 32'hFFFF_FFFF : s[31:0];
            end else begin
                t = din_r;
                m_vld[i][key] = 1;
                m_occ[i]++;
            end
            m_mem[i][key] = t;
            if (dk > dh) m_head[i] = key;
        end
        if (load) begin
            if (m_vld[i][m_rd[i]]) begin
                em = 1;
                w = m_mem[i][m_rd[i]];
                m_vld[i][m_rd[i]] = 0;
                m_occ[i]--;
            end else if (i == 1) begin
                em = 1;
                w[38:32] = 7'(m_rd[i]);
            end
            if (m_head[i] == m_rd[i]) m_head[i] = (m_rd[i] + 1) % DEPTH;
            m_rd[i] = (m_rd[i] + 1) % DEPTH;
        end
        if (em) begin
            m_mv[i] = 1;
            m_dout[i] = w;
        end else if (tready) m_mv[i] = 0;
        m_rdy[i] = 1;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // every-cycle comparison of both variants against the model, plus capture of accepted beats
    always @(negedge clock) begin
        chk("rdy0", 64'(bus0.s_axis_tready), 64'(m_rdy[0]));
        chk("mv0", 64'(bus0.m_axis_tvalid), 64'(m_mv[0]));
        chk("dout0", bus0.dout, m_dout[0]);
        chk("occ0", 64'(occ0), 64'(m_occ[0]));
        chk("late0", 64'(late0), 64'(m_late[0]));
        chk("rdy1", 64'(bus1.s_axis_tready), 64'(m_rdy[1]));
        chk("mv1", 64'(bus1.m_axis_tvalid), 64'(m_mv[1]));
        chk("dout1", bus1.dout, m_dout[1]);
        chk("occ1", 64'(occ1), 64'(m_occ[1]));
        chk("late1", 64'(late1), 64'(m_late[1]));
        if (reset_n && tready && bus0.m_axis_tvalid) q0.push_back(bus0.dout);
        if (reset_n && tready && bus1.m_axis_tvalid) q1.push_back(bus1.dout);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic beat(input int key, input logic [31:0] val);
        din_r = {25'($urandom), 7'(key), val};
        sv = 1;
        idle(1);
        sv = 0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset_n = 0;
        sv = 0; flush = 0; tready = 1;
        idle(2);
        reset_n = 1;
        q0.delete();
        q1.delete();
        idle(1);
    endtask

    initial begin
        logic [63:0] w;
        int off, r;
        idle(2);
        chk("reset_rdy", 64'(bus0.s_axis_tready), 64'd0);
        chk("reset_mv", 64'(bus0.m_axis_tvalid), 64'd0);
        chk("reset_dout", bus0.dout, 64'd0);
        chk("reset_occ", 64'(occ0), 64'd0);
        chk("reset_late", 64'(late1), 64'd0);
        reset_n = 1;
        idle(1);
        chk("rdy_after_reset", 64'(bus0.s_axis_tready), 64'd1);

        // accumulate into slot 3, skip the empty slots around it
        beat(3, 5);
        chk("t1_occ_a", 64'(occ0), 64'd1);
        beat(3, 7);
        chk("t1_occ_b", 64'(occ0), 64'd1);
        beat(6, 1);
        chk("t1_occ_c", 64'(occ0), 64'd2);
        idle(6);
        chk("t1_beats0", 64'(q0.size()), 64'd1);
        w = q0[0];
        chk("t1_val", 64'(w[31:0]), 64'd12);
        chk("t1_key", 64'(w[38:32]), 64'd3);
        chk("t1_occ_end", 64'(occ0), 64'd1);
        chk("t1_model_occ", 64'(m_occ[0]), 64'd1);
        chk("t1_beats1", 64'(q1.size()), 64'd5);

        // saturate versus wrap
        do_reset();
        beat(2, 32'hFFFF_FFF0);
        beat(2, 32'h20);
        beat(9, 0);
        idle(12);
        chk("t2_beats0", 64'(q0.size()), 64'd1);
        w = q0[0];
        chk("t2_wrap", 64'(w[31:0]), 64'h10);
        chk("t2_beats1", 64'(q1.size()), 64'd8);
        w = q1[2];
        chk("t2_sat", 64'(w[31:0]), 64'hFFFF_FFFF);

        // backpressure holds the output stable, then two back-to-back beats
        do_reset();
        tready = 0;
        beat(1, 11);
        beat(2, 22);
        beat(5, 0);
        idle(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t3_hold_mv", 64'(bus0.m_axis_tvalid), 64'd1);
            chk("t3_hold_val", 64'(bus0.dout[31:0]), 64'd11);
        end
        @(posedge clock);
        #1 tready = 1;
        @(negedge clock);
        chk("t3_first_mv", 64'(bus0.m_axis_tvalid), 64'd1);
        chk("t3_first_val", 64'(bus0.dout[31:0]), 64'd11);
        @(negedge clock);
        chk("t3_second_mv", 64'(bus0.m_axis_tvalid), 64'd1);
        chk("t3_second_val", 64'(bus0.dout[31:0]), 64'd22);

        // late beat behind rd_ptr = 10
        do_reset();
        beat(11, 0);
        idle(14);
        chk("t4_rd_model", 64'(m_rd[0]), 64'd10);
        beat(8, 5);
        idle(2);
        chk("t4_late0", 64'(late0), 64'd1);
        chk("t4_late1", 64'(late1), 64'd1);
        chk("t4_occ", 64'(occ0), 64'd1);
        chk("t4_no_out", 64'(q0.size()), 64'd0);

        // flush with empty-slot emission
        do_reset();
        beat(1, 10);
        beat(2, 20);
        flush = 1;
        idle(8);
        flush = 0;
        chk("t5_beats1", 64'(q1.size()), 64'd3);
        chk("t5_empty0", q1[0], 64'd0);
        w = q1[1];
        chk("t5_key1", 64'(w[38:32]), 64'd1);
        chk("t5_val1", 64'(w[31:0]), 64'd10);
        w = q1[2];
        chk("t5_key2", 64'(w[38:32]), 64'd2);
        chk("t5_val2", 64'(w[31:0]), 64'd20);
        chk("t5_occ", 64'(occ1), 64'd0);
        chk("t5_idle", 64'(bus1.m_axis_tvalid), 64'd0);
        chk("t5_beats0", 64'(q0.size()), 64'd2);

        // write into the slot being loaded, then reset mid-transfer
        do_reset();
        beat(0, 4);
        flush = 1;
        beat(0, 6);
        flush = 0;
        idle(3);
        chk("t6_beats", 64'(q0.size()), 64'd1);
        w = q0[0];
        chk("t6_bypass_val", 64'(w[31:0]), 64'd10);
        chk("t6_occ", 64'(occ0), 64'd0);
        beat(0, 0);
        tready = 0;
        beat(3, 1);
        beat(6, 1);
        idle(4);
        chk("t6_pending", 64'(bus0.m_axis_tvalid), 64'd1);
        chk("t6_late_pre", 64'(late0), 64'd1);
        @(posedge clock);
        #3 reset_n = 0;
        #1;
        chk("t6_rst_mv", 64'(bus0.m_axis_tvalid), 64'd0);
        chk("t6_rst_occ", 64'(occ0), 64'd0);
        chk("t6_rst_late", 64'(late0), 64'd0);
        tready = 1;
        do_reset();

        // randomized traffic around the read pointer
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom % 10);
            off = r < 8 ? int'($urandom_range(0, 5)) : r == 8 ? int'($urandom_range(124, 127))
                                                            : int'($urandom_range(0, 127));
            din_r = {$urandom, $urandom};
            din_r[38:32] = 7'((m_rd[0] + off) % DEPTH);
            if ($urandom % 2 == 0) din_r[31:0] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            sv = ($urandom % 10) < 7;
            tready = ($urandom % 4) != 0;
            if ($urandom % 20 == 0) flush = ~flush;
            idle(1);
        end
        sv = 0;
        tready = 1;
        flush = 1;
        idle(200);
        flush = 0;
        chk("drain_occ0", 64'(occ0), 64'd0);
        chk("drain_occ1", 64'(occ1), 64'd0);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
